// File: rtl/frame_pkg.sv
// Shared frame-format constants, FSM encoding and round-robin helper.
package frame_pkg;

    // Footer marker lives in the top byte of a 64-bit frame word.
    localparam logic [7:0]  FOOTER_MARKER_DEF = 8'h55;
    localparam int unsigned MARKER_MSB        = 63;
    localparam int unsigned MARKER_LSB        = 56;
    // Header fields carried by the frame generator (channel id and frame tag).
    localparam int unsigned HDR_CH_MSB        = 55;
    localparam int unsigned HDR_CH_LSB        = 48;
    localparam int unsigned HDR_TAG_MSB       = 47;
    localparam int unsigned HDR_TAG_LSB       = 32;

    // Arbiter helper works on the largest supported channel count.
    localparam int unsigned RR_MAX_CH = 16;
    localparam int unsigned RR_ID_W   = 4;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_PASS = 2'd1;
    localparam fsm_state_t ST_DROP = 2'd2;

    // First requester strictly after last, wrapping; unused request bits must be zero,
    // which makes wrapping modulo 16 equivalent to wrapping modulo the real channel count.
    function automatic logic [RR_ID_W-1:0] next_rr_grant(input logic [RR_MAX_CH-1:0] req,
                                                         input logic [RR_ID_W-1:0]   last);
        logic [RR_ID_W-1:0] idx;
        logic               found;
        next_rr_grant = last;
        found         = 1'b0;
        for (int i = 1; i <= int'(RR_MAX_CH); i++) begin
            idx = last + RR_ID_W'(i);
            if (!found && req[idx]) begin
                next_rr_grant = idx;
                found         = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: registered upstream ready, registered master outputs.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 68
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] skid_data_d;
    logic             skid_valid_d;
    logic             push;
    logic             pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Next-state: refill output from skid on pop, park incoming word in skid when output is busy.
    always_comb begin
        out_data_d   = out_data;
        out_valid_d  = out_valid;
        skid_data_d  = skid_data;
        skid_valid_d = skid_valid;
        if (pop) begin
            if (skid_valid) begin
                out_data_d   = skid_data;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (push) begin
            if (!out_valid_d) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end
    end

    // Slice registers; ready is registered from the next skid occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            out_data   <= out_data_d;
            out_valid  <= out_valid_d;
            skid_data  <= skid_data_d;
            skid_valid <= skid_valid_d;
            in_ready   <= ~skid_valid_d;
        end
    end

endmodule

// File: rtl/frame_stream_merger.sv
// Round-robin frame-granular merger of per-channel frame streams onto one AXI-Stream master.
module frame_stream_merger
    import frame_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DOUT_WIDTH      = 64,
    parameter logic [7:0]  FOOTER_MARKER   = FOOTER_MARKER_DEF,
    parameter int unsigned MAX_FRAME_WORDS = 256,
    parameter int unsigned CH_ID_WIDTH     = $clog2(NUM_CH)
) (
    input  logic                         RD_CLK,
    input  logic                         RD_RESET,
    input  logic [NUM_CH*DOUT_WIDTH-1:0] DIN,
    input  logic [NUM_CH-1:0]            iVALID,
    output logic [NUM_CH-1:0]            oREADY,
    output logic [DOUT_WIDTH-1:0]        M_AXIS_TDATA,
    output logic                         M_AXIS_TVALID,
    input  logic                         M_AXIS_TREADY,
    output logic                         M_AXIS_TLAST,
    output logic [CH_ID_WIDTH:0]         M_AXIS_TUSER,
    output logic [NUM_CH-1:0]            OVERLEN_ERR,
    output logic [31:0]                  FRAME_CNT
);

    localparam int unsigned    CNT_W    = $clog2(MAX_FRAME_WORDS + 1);
    localparam int unsigned    SKID_W   = DOUT_WIDTH + CH_ID_WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_FRAME_WORDS);

    fsm_state_t             state_q, state_d;
    logic [CH_ID_WIDTH-1:0] grant_q, grant_d;
    logic [CH_ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d, word_cnt_inc;
    logic [NUM_CH-1:0]      overlen_q, overlen_d;
    logic [31:0]            frame_cnt_q;

    logic [DOUT_WIDTH-1:0]  din_arr [NUM_CH];
    logic [DOUT_WIDTH-1:0]  din_sel;
    logic                   valid_sel;
    logic                   is_footer;
    logic [NUM_CH-1:0]      ready_c;
    logic                   push_c;
    logic                   tlast_c;
    logic                   trunc_c;
    logic                   skid_in_ready;
    logic [SKID_W-1:0]      skid_in_data;
    logic [SKID_W-1:0]      skid_out_data;

    // Unpack the flat channel bus.
    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_din
        assign din_arr[k] = DIN[k*DOUT_WIDTH +: DOUT_WIDTH];
    end

    assign din_sel      = din_arr[grant_q];
    assign valid_sel    = iVALID[grant_q];
    assign is_footer    = (din_sel[MARKER_MSB:MARKER_LSB] == FOOTER_MARKER);
    assign word_cnt_inc = (word_cnt_q == CNT_SAT) ? word_cnt_q : word_cnt_q + CNT_W'(1);

    // Arbitration, pass/drop control and truncation detection.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        word_cnt_d   = word_cnt_q;
        overlen_d    = overlen_q;
        ready_c      = '0;
        push_c       = 1'b0;
        tlast_c      = 1'b0;
        trunc_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|iVALID) begin
                    grant_d    = CH_ID_WIDTH'(next_rr_grant(RR_MAX_CH'(iVALID),
                                                            RR_ID_W'(last_grant_q)));
                    word_cnt_d = '0;
                    state_d    = ST_PASS;
                end
            end
            ST_PASS: begin
                ready_c[grant_q] = skid_in_ready;
                if (valid_sel && skid_in_ready) begin
                    push_c     = 1'b1;
                    word_cnt_d = word_cnt_inc;
                    if (is_footer) begin
                        tlast_c      = 1'b1;
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else if (word_cnt_q == LAST_IDX) begin
                        tlast_c            = 1'b1;
                        trunc_c            = 1'b1;
                        overlen_d[grant_q] = 1'b1;
                        state_d            = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                // Drain the runaway frame without touching the output side.
                ready_c[grant_q] = 1'b1;
                if (valid_sel) begin
                    word_cnt_d = word_cnt_inc;
                    if (is_footer) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; last_grant resets to the top channel so channel 0 wins first.
    always_ff @(posedge RD_CLK) begin
        if (RD_RESET) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_ID_WIDTH'(NUM_CH - 1);
            word_cnt_q   <= '0;
            overlen_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_cnt_q   <= word_cnt_d;
            overlen_q    <= overlen_d;
        end
    end

    // Count frames as they leave on the master port.
    always_ff @(posedge RD_CLK) begin
        if (RD_RESET) begin
            frame_cnt_q <= '0;
        end else if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign skid_in_data = {din_sel, tlast_c, trunc_c, grant_q};

    axis_skid_buffer #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk       (RD_CLK),
        .rst       (RD_RESET),
        .in_data   (skid_in_data),
        .in_valid  (push_c),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out_data),
        .out_valid (M_AXIS_TVALID),
        .out_ready (M_AXIS_TREADY)
    );

    assign {M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER} = skid_out_data;
    assign oREADY      = ready_c;
    assign OVERLEN_ERR = overlen_q;
    assign FRAME_CNT   = frame_cnt_q;

endmodule
